// File: rtl/seq_shift_add_mult_pkg.sv
// Shared constants for the shift-and-add multiplier: FSM state encodings
// (the divider's control FSM uses the same codes) and the default width.
package seq_shift_add_mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : seq_shift_add_mult_pkg

// File: rtl/seq_shift_add_mult_if.sv
// go/done operand interface of the multiplier. The control FSM is the master
// and the multiplier is the slave.
interface seq_shift_add_mult_if
  import seq_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               go;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] P;
  logic               busy;
  logic               done;

  modport master (output go, A, B, input  P, busy, done);
  modport slave  (input  go, A, B, output P, busy, done);

endinterface : seq_shift_add_mult_if

// File: rtl/seq_shift_add_mult_p_shift_reg.sv
// {acc,q} product shift register: ld clears acc and loads the multiplier into q,
// sr shifts right while loading the adder result into the high half.
module seq_shift_add_mult_p_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sr,
  input  logic [WIDTH-1:0] ld_q,
  input  logic [WIDTH:0]   sum,
  output logic [WIDTH:0]   acc,
  output logic [WIDTH-1:0] q,
  output logic             lsb
);

  logic [2*WIDTH:0] r;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create simulation/synthesis ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
    end else if (ld) begin
      r <= {{(WIDTH+1){1'b0}}, ld_q};
    end else if (sr) begin
      // The carry sits in sum[WIDTH] and lands in acc's MSB-1 after the shift.
      r <= {sum, q} >> 1;
    end
  end

  assign acc = r[2*WIDTH:WIDTH];
  assign q   = r[WIDTH-1:0];
  assign lsb = r[0];

endmodule : seq_shift_add_mult_p_shift_reg

// File: rtl/seq_shift_add_mult.sv
// Unsigned sequential shift-and-add multiplier: one operand pair per go/done
// handshake, 2*WIDTH product after WIDTH add-and-shift iterations.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_shift_add_mult_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   m;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] p_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   q;
  logic               lsb;
  logic               ld;
  logic               sr;

  assign ld  = (state == ST_IDLE) && bus.go;
  assign sr  = (state == ST_CALC);
  assign sum = acc + (lsb ? {1'b0, m} : '0);

  seq_shift_add_mult_p_shift_reg #(
    .WIDTH (WIDTH)
  ) u_p_shift_reg (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .sr   (sr),
    .ld_q (bus.B),
    .sum  (sum),
    .acc  (acc),
    .q    (q),
    .lsb  (lsb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      m      <= '0;
      cnt    <= '0;
      p_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.go) begin
            m      <= bus.A;
            cnt    <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_CALC;
        end
        ST_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Same value the shift register takes this edge, minus its always-zero MSB.
            p_q    <= {sum, q[WIDTH-1:1]};
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.P    = p_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : seq_shift_add_mult

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult at WIDTH=4: directed cases, async
// reset mid-operation and an exhaustive operand sweep.
module tb_seq_shift_add_mult;

  localparam int W      = 4;
  localparam int BUDGET = 50;

  logic clk;
  logic rst;

  seq_shift_add_mult_if #(.WIDTH(W)) bus ();

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int n_go     = 0;
  int n_done   = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] exp_p = '0;
  logic           prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      n_done++;
      check("done_single_cycle", prev_done, 0);
      check("done_has_go", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_p = sb.pop_front();
        check("P", bus.P, exp_p);
      end
    end
    prev_done = bus.done;
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = a;
    eb = b;
    @(negedge clk);
    bus.go = 1'b1;
    bus.A  = a;
    bus.B  = b;
    sb.push_back(ea * eb);
    n_go++;
    @(posedge clk);
    #1;
    if (!hold) bus.go = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
  endtask

  // Counts non-done negedges after the accept edge until done is seen.
  task automatic wait_done(output int cycles, output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    cycles      = 0;
    busy_cycles = 0;
    while (!seen && cycles <= BUDGET) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        if (bus.busy === 1'b1) busy_cycles++;
        cycles++;
      end
    end
    if (!seen) check("done_timeout", cycles, BUDGET);
  endtask

  initial begin
    int cyc;
    int bcyc;
    rst    = 1'b1;
    bus.go = 1'b0;
    bus.A  = '0;
    bus.B  = '0;
    #2 rst = 1'b0;
    #1;
    check("reset_P", bus.P, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Largest operands: carry must survive every add.
    start(4'd15, 4'd15, 1'b0);
    wait_done(cyc, bcyc);
    check("lat_15x15", cyc, W + 1);
    check("busy_cycles_15x15", bcyc, W + 1);
    check("busy_low_with_done", bus.busy, 0);
    @(negedge clk);
    check("done_dropped", bus.done, 0);
    repeat (3) @(negedge clk);
    check("P_hold_idle", bus.P, 8'hE1);

    // Zero operands still take full latency.
    start(4'd0, 4'd13, 1'b0);
    wait_done(cyc, bcyc);
    check("lat_0x13", cyc, W + 1);
    start(4'd9, 4'd0, 1'b0);
    wait_done(cyc, bcyc);
    check("lat_9x0", cyc, W + 1);

    // Back-to-back with go held high through DONE.
    start(4'd9, 4'd1, 1'b1);
    bus.A = 4'd6;
    bus.B = 4'd11;
    sb.push_back(8'd66);
    n_go++;
    wait_done(cyc, bcyc);
    check("lat_9x1", cyc, W + 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reaccept_first_idle_edge", bus.busy, 1);
    bus.go = 1'b0;
    bus.A  = 4'd3;
    bus.B  = 4'd2;
    wait_done(cyc, bcyc);
    check("lat_6x11", cyc, W + 1);

    // go during CALC is ignored, operands already captured.
    start(4'd7, 4'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.go = 1'b1;
    bus.A  = 4'd15;
    bus.B  = 4'd15;
    @(negedge clk);
    bus.go = 1'b0;
    bus.A  = 4'd1;
    bus.B  = 4'd2;
    wait_done(cyc, bcyc);
    repeat (2) @(negedge clk);
    check("P_after_ignored_go", bus.P, 8'h15);

    // Async reset mid-CALC abandons the operation.
    start(4'd12, 4'd12, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midreset_P", bus.P, 0);
    check("midreset_busy", bus.busy, 0);
    check("midreset_done", bus.done, 0);
    void'(sb.pop_back());
    n_go--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    start(4'd5, 4'd5, 1'b0);
    wait_done(cyc, bcyc);
    check("lat_after_reset", cyc, W + 1);
    repeat (2) @(negedge clk);
    check("P_5x5_hold", bus.P, 8'h19);

    // Exhaustive sweep; products checked by the scoreboard consumer.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start(W'(a), W'(b), 1'b0);
        wait_done(cyc, bcyc);
      end
    end

    repeat (4) @(negedge clk);
    check("done_count_eq_go_count", n_done, n_go);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_seq_shift_add_mult
